// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store initiator for dataMem with read-modify-write stores
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqSigned,
    input  logic [23:0] reqAddr,
    input  logic [31:0] reqData,
    output logic        respValid,
    output logic [31:0] respData,
    output logic        respFault,
    output logic [21:0] memAddress,
    output logic [31:0] memDataOut,
    output logic        memWriteEnable,
    input  logic [31:0] memDataIn
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state;
    logic        latWrite;
    logic [1:0]  latSize;
    logic        latSigned;
    logic [1:0]  latLane;
    logic [31:0] latData;
    logic        faultReg;
    logic [31:0] wordReg;

    logic        reqFault;
    logic [7:0]  laneByte;
    logic [15:0] laneHalf;
    logic [31:0] loadResult;
    logic [31:0] mergedWord;

    assign reqReady = (state == IDLE) && reset;

    // Illegal size or an access that does not sit on its natural alignment.
    always_comb begin
        reqFault = 1'b0;
        case (reqSize)
            2'b01:   reqFault = reqAddr[0];
            2'b10:   reqFault = (reqAddr[1:0] != 2'b00);
            2'b11:   reqFault = 1'b1;
            default: reqFault = 1'b0;
        endcase
    end

    // Pick the addressed lane out of the captured word and extend it.
    always_comb begin
        laneByte = 8'h00;
        case (latLane)
            2'd0: laneByte = wordReg[7:0];
            2'd1: laneByte = wordReg[15:8];
            2'd2: laneByte = wordReg[23:16];
            2'd3: laneByte = wordReg[31:24];
            default: laneByte = 8'h00;
        endcase
        laneHalf   = latLane[1] ? wordReg[31:16] : wordReg[15:0];
        loadResult = wordReg;
        case (latSize)
            2'b00:   loadResult = {{24{latSigned & laneByte[7]}}, laneByte};
            2'b01:   loadResult = {{16{latSigned & laneHalf[15]}}, laneHalf};
            default: loadResult = wordReg;
        endcase
    end

    // Replace the target lane(s) of the word being read, keeping the rest.
    always_comb begin
        mergedWord = memDataIn;
        if (latSize == 2'b00) begin
            case (latLane)
                2'd0: mergedWord[7:0]   = latData[7:0];
                2'd1: mergedWord[15:8]  = latData[7:0];
                2'd2: mergedWord[23:16] = latData[7:0];
                2'd3: mergedWord[31:24] = latData[7:0];
                default: mergedWord = memDataIn;
            endcase
        end else if (latLane[1]) begin
            mergedWord[31:16] = latData[15:0];
        end else begin
            mergedWord[15:0] = latData[15:0];
        end
    end

    // Request FSM; memory-side and response outputs are all registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            latWrite       <= 1'b0;
            latSize        <= 2'b00;
            latSigned      <= 1'b0;
            latLane        <= 2'b00;
            latData        <= 32'h0;
            faultReg       <= 1'b0;
            wordReg        <= 32'h0;
            respValid      <= 1'b0;
            respFault      <= 1'b0;
            respData       <= 32'h0;
            memAddress     <= 22'h0;
            memDataOut     <= 32'h0;
            memWriteEnable <= 1'b0;
        end else begin
            respValid <= 1'b0;
            respFault <= 1'b0;
            respData  <= 32'h0;
            case (state)
                IDLE: begin
                    if (reqValid) begin
                        latWrite  <= reqWrite;
                        latSize   <= reqSize;
                        latSigned <= reqSigned;
                        latLane   <= reqAddr[1:0];
                        latData   <= reqData;
                        faultReg  <= reqFault;
                        if (reqFault) begin
                            state <= RESP;
                        end else begin
                            memAddress <= reqAddr[23:2];
                            if (reqWrite && (reqSize == 2'b10)) begin
                                memDataOut     <= reqData;
                                memWriteEnable <= 1'b1;
                                state          <= WRITE;
                            end else begin
                                state <= READ;
                            end
                        end
                    end
                end
                READ: begin
                    wordReg <= memDataIn;
                    if (latWrite) begin
                        memDataOut     <= mergedWord;
                        memWriteEnable <= 1'b1;
                        state          <= WRITE;
                    end else begin
                        state <= RESP;
                    end
                end
                WRITE: begin
                    memWriteEnable <= 1'b0;
                    state          <= RESP;
                end
                RESP: begin
                    respValid <= 1'b1;
                    respFault <= faultReg;
                    respData  <= (faultReg || latWrite) ? 32'h0 : loadResult;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized bench for load_store_unit with behavioural memory model
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [1:0]  reqSize;
    logic        reqSigned;
    logic [23:0] reqAddr;
    logic [31:0] reqData;
    logic        respValid;
    logic [31:0] respData;
    logic        respFault;
    logic [21:0] memAddress;
    logic [31:0] memDataOut;
    logic        memWriteEnable;
    logic [31:0] memDataIn;

    load_store_unit dut (
        .clk(clk), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqSize(reqSize), .reqSigned(reqSigned), .reqAddr(reqAddr), .reqData(reqData),
        .respValid(respValid), .respData(respData), .respFault(respFault),
        .memAddress(memAddress), .memDataOut(memDataOut),
        .memWriteEnable(memWriteEnable), .memDataIn(memDataIn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nTests = 0;
    int nFail  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // dataMem stand-in: 16 physical words, unwritten words hold a fixed pattern
    logic [31:0] memArr [0:15];
    logic [15:0] memValid = 16'h0;

    function automatic logic [31:0] initWord(int idx);
        logic [31:0] v;
        v = 32'h9E3779B9 * (idx + 1);
        return v ^ 32'h5A5A0000;
    endfunction

    assign memDataIn = memValid[memAddress[3:0]] ? memArr[memAddress[3:0]]
                                                 : initWord(int'(memAddress[3:0]));

    always @(posedge clk) begin
        if (memWriteEnable) begin
            memArr[memAddress[3:0]]   <= memDataOut;
            memValid[memAddress[3:0]] <= 1'b1;
        end
    end

    // Reference model state
    logic [31:0] modelMem [int];
    int          doneCyc    = 0;
    int          expRespCyc = -100;
    int          expWrCyc   = -100;
    logic [31:0] expRespData;
    logic        expFault;
    logic [21:0] expWrAddr;
    logic [31:0] expWrData;
    int          lastAcc = 0;
    int          lastRespCyc = 0;
    logic [31:0] lastRespData = 32'h0;
    logic        lastRespFault = 1'b0;
    logic [21:0] lastWrAddr = 22'h0;
    logic [31:0] lastWrData = 32'h0;
    int          respCount = 0;
    int          wrCount = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] loadVal(logic [31:0] w, logic [1:0] sz, logic [1:0] lane, logic sg);
        logic [31:0] v;
        if (sz == 2'b00) begin
            v = (w >> (8 * int'(lane))) & 32'hFF;
            if (sg && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 2'b01) begin
            v = (w >> (16 * int'(lane[1]))) & 32'hFFFF;
            if (sg && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] mergeVal(logic [31:0] w, logic [31:0] d, logic [1:0] sz, logic [1:0] lane);
        logic [31:0] mask;
        int sh;
        if (sz == 2'b10) return d;
        if (sz == 2'b00) begin
            sh = 8 * int'(lane);
            mask = 32'hFF << sh;
        end else begin
            sh = 16 * int'(lane[1]);
            mask = 32'hFFFF << sh;
        end
        return (w & ~mask) | ((d << sh) & mask);
    endfunction

    // Cycle-by-cycle comparison against the model's expected schedule
    always @(negedge clk) begin
        chk("reqReady", reqReady, reset && (cyc >= doneCyc));
        chk("respValid", respValid, cyc == expRespCyc);
        chk("memWriteEnable", memWriteEnable, cyc == expWrCyc);
        if (respValid && cyc == expRespCyc) begin
            chk("respData", respData, expRespData);
            chk("respFault", respFault, expFault);
            lastRespCyc   = cyc;
            lastRespData  = respData;
            lastRespFault = respFault;
        end
        if (respValid) respCount++;
        if (memWriteEnable) begin
            wrCount++;
            lastWrAddr = memAddress;
            lastWrData = memDataOut;
            if (cyc == expWrCyc) begin
                chk("memAddress", memAddress, expWrAddr);
                chk("memDataOut", memDataOut, expWrData);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic waitDone();
        while (cyc <= doneCyc) tick();
    endtask

    task automatic doReq(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [23:0] a, input logic [31:0] d, input bit abort);
        int waitN;
        int wa;
        int lat;
        logic [31:0] old;
        logic [31:0] nw;
        bit flt;
        tick();
        reqValid  = 1'b1;
        reqWrite  = w;
        reqSize   = sz;
        reqSigned = sg;
        reqAddr   = a;
        reqData   = d;
        waitN = 0;
        while (!reqReady && waitN < 20) begin
            tick();
            waitN++;
        end
        if (!reqReady) begin
            chk("acceptTimeout", 32'd0, 32'd1);
            reqValid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        lastAcc = cyc;
        wa  = int'(a[23:2]);
        flt = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        old = modelMem[wa];
        if (flt) lat = 1;
        else if (!w || sz == 2'b10) lat = 2;
        else lat = 3;
        doneCyc     = lastAcc + lat;
        expRespCyc  = lastAcc + lat;
        expFault    = flt;
        expRespData = (!flt && !w) ? loadVal(old, sz, a[1:0], sg) : 32'h0;
        if (!flt && w) begin
            nw        = mergeVal(old, d, sz, a[1:0]);
            expWrCyc  = lastAcc + ((sz == 2'b10) ? 0 : 1);
            expWrAddr = a[23:2];
            expWrData = nw;
            if (!abort) modelMem[wa] = nw;
        end else begin
            expWrCyc = -100;
        end
        if (abort) begin
            tick();
            expRespCyc = -100;
            expWrCyc   = -100;
            doneCyc    = -100;
            reqValid   = 1'b0;
            reset      = 1'b0;
            tick();
            tick();
            reset = 1'b1;
            tick();
            chk("readyAfterReset", reqReady, 1'b1);
        end
    endtask

    int accA;
    int rc0;
    int wc0;
    logic [1:0]  rSize;
    logic [1:0]  rLane;
    logic [21:0] rWord;

    initial begin
        for (int i = 0; i < 15; i++) modelMem[i] = initWord(i);
        modelMem[32'h3FFFFF] = initWord(15);
        reset = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00;
        reqSigned = 1'b0; reqAddr = 24'h0; reqData = 32'h0;
        tick();
        chk("rstRespValid", respValid, 1'b0);
        chk("rstRespFault", respFault, 1'b0);
        chk("rstRespData", respData, 32'h0);
        chk("rstMemWe", memWriteEnable, 1'b0);
        chk("rstMemAddr", memAddress, 22'h0);
        chk("rstMemDataOut", memDataOut, 32'h0);
        chk("rstReqReady", reqReady, 1'b0);
        tick();
        reset = 1'b1;

        // Word store then word load
        wc0 = wrCount;
        doReq(1'b1, 2'b10, 1'b0, 24'h000010, 32'hDEADBEEF, 1'b0);
        reqValid = 1'b0; waitDone();
        chk("wsWrites", wrCount - wc0, 1);
        chk("wsAddr", lastWrAddr, 22'h000004);
        chk("wsLatency", lastRespCyc - lastAcc, 2);
        doReq(1'b0, 2'b10, 1'b0, 24'h000010, 32'h0, 1'b0);
        reqValid = 1'b0; waitDone();
        chk("wlData", lastRespData, 32'hDEADBEEF);
        chk("wlLatency", lastRespCyc - lastAcc, 2);

        // Byte store via read-modify-write
        doReq(1'b1, 2'b00, 1'b0, 24'h000013, 32'h00000055, 1'b0);
        reqValid = 1'b0; waitDone();
        chk("bsMerged", lastWrData, 32'h55ADBEEF);
        chk("bsLatency", lastRespCyc - lastAcc, 3);

        // Extended loads
        doReq(1'b0, 2'b01, 1'b1, 24'h000010, 32'h0, 1'b0);
        reqValid = 1'b0; waitDone();
        chk("hlSigned", lastRespData, 32'hFFFFBEEF);
        doReq(1'b0, 2'b01, 1'b0, 24'h000010, 32'h0, 1'b0);
        reqValid = 1'b0; waitDone();
        chk("hlUnsigned", lastRespData, 32'h0000BEEF);
        doReq(1'b0, 2'b00, 1'b1, 24'h000013, 32'h0, 1'b0);
        reqValid = 1'b0; waitDone();
        chk("blSigned", lastRespData, 32'h00000055);

        // Faults
        wc0 = wrCount;
        doReq(1'b0, 2'b01, 1'b0, 24'h000011, 32'h0, 1'b0);
        reqValid = 1'b0; waitDone();
        chk("fltFlag", lastRespFault, 1'b1);
        chk("fltData", lastRespData, 32'h0);
        chk("fltLatency", lastRespCyc - lastAcc, 1);
        doReq(1'b1, 2'b11, 1'b0, 24'h000010, 32'h12345678, 1'b0);
        reqValid = 1'b0; waitDone();
        chk("fltSize3", lastRespFault, 1'b1);
        chk("fltNoWrite", wrCount - wc0, 0);

        // Reset during the READ cycle of a byte store
        wc0 = wrCount; rc0 = respCount;
        doReq(1'b1, 2'b00, 1'b0, 24'h000013, 32'h000000AA, 1'b1);
        chk("abortNoWrite", wrCount - wc0, 0);
        chk("abortNoResp", respCount - rc0, 0);
        doReq(1'b0, 2'b10, 1'b0, 24'h000010, 32'h0, 1'b0);
        reqValid = 1'b0; waitDone();
        chk("abortMemKept", lastRespData, 32'h55ADBEEF);

        // reqValid held across a busy period: one accept per IDLE visit
        rc0 = respCount;
        doReq(1'b0, 2'b10, 1'b0, 24'h000010, 32'h0, 1'b0);
        accA = lastAcc;
        doReq(1'b0, 2'b00, 1'b0, 24'h000012, 32'h0, 1'b0);
        chk("holdSpacing", lastAcc - accA, 3);
        reqValid = 1'b0; waitDone();
        chk("holdRespCount", respCount - rc0, 2);
        chk("holdSecond", lastRespData, 32'h000000AD);

        // Top word address is legal
        doReq(1'b1, 2'b10, 1'b0, 24'hFFFFFC, 32'hCAFEF00D, 1'b0);
        reqValid = 1'b0; waitDone();
        chk("topAddr", lastWrAddr, 22'h3FFFFF);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            rSize = 2'($urandom_range(0, 3));
            rLane = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                if (rSize == 2'b10) rLane = 2'b00;
                else if (rSize == 2'b01) rLane[0] = 1'b0;
            end
            rWord = ($urandom_range(0, 7) == 0) ? 22'h3FFFFF : 22'($urandom_range(0, 14));
            doReq(1'($urandom_range(0, 1)), rSize, 1'($urandom_range(0, 1)),
                  {rWord, rLane}, $urandom, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                reqValid = 1'b0;
                repeat ($urandom_range(0, 3)) tick();
            end
        end
        reqValid = 1'b0;
        waitDone();
        tick();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
